// File: rtl/dmem_boot_arbiter.sv
// Boot sequencer and data-memory port arbiter: LOAD -> RUN -> HALT. Grants are combinational, so an access is acked in the cycle it is granted.
// A losing requester waits; `DMEM_STARVE_GUARD_EN adds a starvation guard that gives ext one forced RUN cycle.
module dmem_boot_arbiter #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(32'h02000004),
  parameter logic [31:0]       HALT_VALUE   = 32'd5,
  parameter int                MAX_CYCLES   = 10000,
  parameter int                CNT_W        = 32,
  parameter int                STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,
  input  logic              ext_load_done,
  input  logic              cpu_mem_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_run,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic [1:0]        halt_code,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} stateT;

  stateT state;
  logic  forceExt;
  logic  cpuGrant;
  logic  extGrant;
  logic  haltHit;
  logic  timeoutHit;

  assign cpu_run = (state == RUN) && !forceExt;

  // Grants are qualified by reset so an access caught by reset is never acked.
  assign cpuGrant = reset && cpu_run && cpu_mem_en;
  assign extGrant = reset && ext_req && !cpuGrant;

  assign ext_ack   = extGrant;
  assign mem_we    = cpuGrant ? cpu_we    : (extGrant && ext_we);
  assign mem_addr  = cpuGrant ? cpu_addr  : ext_addr;
  assign mem_wdata = cpuGrant ? cpu_wdata : ext_wdata;
  assign ext_rdata = mem_rdata;
  assign cpu_rdata = mem_rdata;

  assign haltHit    = cpuGrant && cpu_we && (cpu_addr == HALT_ADDR) && (cpu_wdata == HALT_VALUE);
  assign timeoutHit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      halted      <= 1'b0;
      halt_code   <= 2'd0;
      cycle_count <= '0;
    end else begin
      case (state)
        LOAD: if (ext_load_done) state <= RUN;
        RUN: begin
          if (!(&cycle_count)) cycle_count <= cycle_count + 1'b1;
          if (haltHit) begin
            state     <= HALT;
            halted    <= 1'b1;
            halt_code <= 2'd1;
          end else if (timeoutHit) begin
            state     <= HALT;
            halted    <= 1'b1;
            halt_code <= 2'd2;
          end
        end
        default: state <= state;
      endcase
    end
  end

`ifdef DMEM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starveCnt;

  // The forced cycle always ends the streak, whether or not ext still wants the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
      forceExt  <= 1'b0;
    end else if (state != RUN || ext_ack || forceExt) begin
      starveCnt <= '0;
      forceExt  <= 1'b0;
    end else if (ext_req) begin
      starveCnt <= starveCnt + 1'b1;
      if (starveCnt == SW'(STARVE_LIMIT - 1)) forceExt <= 1'b1;
    end
  end
`else
  // Guard absent: a non-negative limit makes this constant 0, so the core is never forced off.
  assign forceExt = (STARVE_LIMIT < 0);
`endif

endmodule
